fx2_slave_fifo_writer: RTL and testbench
========================================

Name: fx2_slave_fifo_writer

Overview:
- Downstream stage of the asvm12120_fft core.
- Drains finished FFT result words from the internal show-ahead output FIFO and pushes them to the Cypress FX2 slave FIFO on the `ifclk` domain, driving `fd`, `slwr` and `pktend`.
- Respects the FX2 endpoint full flag (`flagb`), auto-commits full packets and forces a short-packet commit at end of frame.

Parameters:
- PKT_WORDS, 256, 16-bit words per FX2 packet (512-byte bulk); power of two, 2..1024.
- EP_ADDR, 2'b10, FIFOADR value selecting the IN endpoint (EP6).
- CNT_W, 16, width of the frame counter.

Ports:
- ifclk  in  1  FX2 interface clock; the only clock of the block.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = transfer allowed; 0 = stop after the current write.
- src_data  in  16  show-ahead FIFO head word.
- src_last  in  1  tag bit: the head word is the last word of an FFT frame.
- src_empty  in  1  source FIFO empty.
- src_rdreq  out  1  pop the head word (combinational; asserted in the cycle the word is taken).
- flagb  in  1  FX2 EP full flag, active low (0 = full). Firmware programs it with at least 2 words of margin.
- fd  out  16  FX2 data bus.
- fd_oe  out  1  output enable for `fd` (1 = drive).
- slwr  out  1  FX2 write strobe, active low.
- slrd  out  1  FX2 read strobe; held at 1.
- pktend  out  1  FX2 packet end, active low.
- fifoadr  out  2  held at EP_ADDR.
- frame_cnt  out  CNT_W  frames fully written; wraps.
- busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Reset values (applied on the first `ifclk` edge with `reset`=1, including mid-operation):
  - `fd`=0, `fd_oe`=0, `slwr`=1, `slrd`=1, `pktend`=1, `fifoadr`=EP_ADDR.
  - `frame_cnt`=0, `busy`=0, state IDLE, `pkt_cnt`=0.
  - `flagb_r` resets to 0.
  - `src_rdreq`=0 while `reset`=1.
  - A word popped in the reset cycle is not required; the bench guarantees that none is.
- Flag sampling: `flagb_r` <= `flagb` each cycle.
- `write_go` = `enable` & `flagb_r` & !`src_empty` & (state is IDLE or WRITE).
- `src_rdreq` = `write_go`.
- Registered write, 1-cycle latency: when `write_go` is 1, on the next edge `fd` <= `src_data`, `slwr` <= 0, `fd_oe` <= 1. Otherwise `slwr` <= 1.
- Back-to-back writes: one word per cycle while `write_go` holds.
- `pkt_cnt` increments (mod PKT_WORDS) on every write. Reaching PKT_WORDS wraps to 0 with no `pktend`; FX2 auto-commits.
- States:
  - IDLE:
    - `write_go` -> WRITE.
  - WRITE:
    - stays while writing or stalled.
    - A word written with `src_last`=1 increments `frame_cnt` in the same edge as its `slwr` assertion.
    - After that word: if the post-increment `pkt_cnt` == 0 -> IDLE; else -> PKTGAP.
    - `enable`=0 with no `src_last` word in flight -> IDLE. No forced `pktend`.
  - PKTGAP:
    - one cycle with `slwr`=1; FX2 forbids `slwr` and `pktend` low together.
    - -> PKTEND.
  - PKTEND:
    - `pktend`=0 for exactly one cycle, `fd_oe` still 1, `pkt_cnt` <= 0.
    - -> IDLE. `src_rdreq`=0 in PKTGAP and PKTEND.
- `fd_oe` falls to 0 one cycle after the last `slwr` or `pktend` assertion when returning to IDLE.
- `busy` = state != IDLE.
- `flagb` falling:
  - Writes stop at most 1 cycle later because of `flagb_r`; at most 2 words are written after the flag falls, covered by the firmware margin.
  - No words are lost: the head word stays in the source FIFO until `flagb_r`=1.
- `src_empty` mid-packet: stall with `slwr`=1 and stay in WRITE. A partial packet stays uncommitted until `src_last` or auto-commit.
- Simultaneous `flagb_r`=0 and `src_last` head: nothing is written. `pktend` is issued only after the last word is actually written.
- `enable` low during PKTGAP or PKTEND: the `pktend` sequence completes.
- `frame_cnt` wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, `flagb`=1, FIFO preloaded with 256 words (last tagged) -> 256 consecutive `slwr`=0 cycles starting 1 cycle after the first `src_rdreq`; `fd` sequence equals the input; no `pktend`; `frame_cnt`=1.
- 100-word frame, last tagged -> 100 writes, then 1 gap cycle, then `pktend`=0 for 1 cycle; `pktend` never overlaps `slwr`=0; `frame_cnt`=1.
- `flagb` pulled to 0 at word 50 for 20 cycles -> at most 2 extra writes, then `slwr`=1; resumes 1 cycle after `flagb` returns to 1; output sequence complete, no duplicates.
- `src_empty` toggled every other cycle over a 300-word frame -> 300 writes: one auto-commit at 256, then `pktend` after word 300.
- `reset` asserted mid-packet at word 37 -> next edge `slwr`=1, `pktend`=1, `fd_oe`=0, `frame_cnt`=0, `busy`=0.
- 2^CNT_W+1 one-word frames with CNT_W=4 -> `frame_cnt` reads 1 after 17 frames; each frame ends with a `pktend` pulse.

Source files
------------

// File: rtl/fx2_slave_fifo_writer.sv
// fx2_slave_fifo_writer: drains a show-ahead result FIFO into the FX2 slave FIFO with packet commit
// Ports: ifclk/reset clock and sync active-high reset; enable gates transfers;
//   src_data/src_last/src_empty/src_rdreq show-ahead FIFO head, tag, empty and pop;
//   flagb EP full flag (0 = full); fd/fd_oe/slwr/slrd/pktend/fifoadr FX2 slave FIFO bus;
//   frame_cnt frames fully written (wraps); busy high whenever not idle.
module fx2_slave_fifo_writer #(
   parameter int         PKT_WORDS = 256,
   parameter logic [1:0] EP_ADDR   = 2'b10,
   parameter int         CNT_W     = 16
) (
   input  logic             ifclk,
   input  logic             reset,
   input  logic             enable,
   input  logic [15:0]      src_data,
   input  logic             src_last,
   input  logic             src_empty,
   output logic             src_rdreq,
   input  logic             flagb,
   output logic [15:0]      fd,
   output logic             fd_oe,
   output logic             slwr,
   output logic             slrd,
   output logic             pktend,
   output logic [1:0]       fifoadr,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             busy
);
   localparam int PW = $clog2(PKT_WORDS);
   typedef enum logic [1:0] {IDLE, WRITE, PKTGAP, PKTEND} state_t;
   state_t        state;
   logic          flagb_r;
   logic [PW-1:0] pkt_cnt;
   logic [PW-1:0] pkt_next;
   logic          write_go;
   assign pkt_next  = pkt_cnt + PW'(1);
   // reset gating keeps the source FIFO untouched during the reset cycle
   assign write_go  = !reset && enable && flagb_r && !src_empty && (state == IDLE || state == WRITE);
   assign src_rdreq = write_go;
   assign slrd      = 1'b1;
   assign fifoadr   = EP_ADDR;
   assign busy      = state != IDLE;
   always_ff @(posedge ifclk) begin
      if (reset) begin
         state     <= IDLE;
         flagb_r   <= 1'b0;
         pkt_cnt   <= '0;
         fd        <= '0;
         fd_oe     <= 1'b0;
         slwr      <= 1'b1;
         pktend    <= 1'b1;
         frame_cnt <= '0;
      end else begin
         flagb_r <= flagb;
         slwr    <= !write_go;
         // outputs trail state by one cycle: PKTGAP shows the last slwr, PKTEND shows the gap
         pktend  <= state != PKTEND;
         if (write_go) begin
            fd      <= src_data;
            fd_oe   <= 1'b1;
            pkt_cnt <= pkt_next;
            if (src_last)
               frame_cnt <= frame_cnt + CNT_W'(1);
         end else if (state == IDLE) begin
            fd_oe <= 1'b0;
         end
         if (state == PKTEND)
            pkt_cnt <= '0;
         // a last word landing on a packet boundary is auto-committed by the FX2, so no pktend
         state <= (state == PKTGAP) ? PKTEND :
                  (state == PKTEND) ? IDLE :
                  write_go ? (src_last ? ((pkt_next == '0) ? IDLE : PKTGAP) : WRITE) :
                  (enable ? state : IDLE);
      end
   end
endmodule

// File: tb/tb_fx2_slave_fifo_writer.sv
// tb_fx2_slave_fifo_writer: randomized bench for fx2_slave_fifo_writer against a cycle model and data scoreboard
module tb_fx2_slave_fifo_writer;
   localparam int PKT = 256;
   localparam int CW  = 4;
   logic          ifclk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [15:0]   src_data = '0;
   logic          src_last = 1'b0;
   logic          src_empty = 1'b1;
   logic          src_rdreq;
   logic          flagb = 1'b1;
   logic [15:0]   fd;
   logic          fd_oe, slwr, slrd, pktend, busy;
   logic [1:0]    fifoadr;
   logic [CW-1:0] frame_cnt;
   always #5 ifclk = ~ifclk;
   fx2_slave_fifo_writer #(.PKT_WORDS(PKT), .EP_ADDR(2'b10), .CNT_W(CW)) dut (
      .ifclk(ifclk), .reset(reset), .enable(enable), .src_data(src_data), .src_last(src_last),
      .src_empty(src_empty), .src_rdreq(src_rdreq), .flagb(flagb), .fd(fd), .fd_oe(fd_oe),
      .slwr(slwr), .slrd(slrd), .pktend(pktend), .fifoadr(fifoadr), .frame_cnt(frame_cnt), .busy(busy)
   );
   logic [16:0] src_q[$];
   logic [15:0] exp_q[$];
   int checks = 0, passed = 0;
   bit m_fr = 0, m_act = 0, m_slwr = 1, m_pktend = 1, m_oe = 0;
   int m_tail = 0, m_pkt = 0, m_frame = 0;
   bit hide = 0, flag_rand = 0, en_rand = 0, rd_s;
   int hide_mode = 0, flag_low = 0, cyc = 0;
   int writes, pktends, overlaps, first_rd, first_wr, last_wr, last_pk, w0;
   task automatic chk(string n, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", n, act, exp);
   endtask
   function automatic bit m_go();
      return !reset && enable && m_fr && !src_empty && m_tail == 0;
   endfunction
   task automatic drive_in();
      if (flag_low > 0) begin
         flagb = 1'b0;
         flag_low--;
      end else flagb = flag_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (en_rand) enable = $urandom_range(0, 5) != 0;
      hide = hide_mode == 1 ? ~hide : hide_mode == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
      src_empty = hide || src_q.size() == 0;
      {src_last, src_data} = (src_q.size() > 0) ? src_q[0] : 17'h0;
   endtask
   task automatic step();
      bit go;
      @(negedge ifclk);
      chk("slwr", slwr, m_slwr);
      chk("pktend", pktend, m_pktend);
      chk("fd_oe", fd_oe, m_oe);
      chk("busy", busy, int'(m_act || m_tail > 0));
      chk("frame_cnt", frame_cnt, m_frame % 16);
      chk("src_rdreq", src_rdreq, m_go());
      chk("slrd", slrd, 1);
      chk("fifoadr", fifoadr, 2);
      if (!slwr) begin
         writes++;
         last_wr = cyc;
         if (first_wr < 0) first_wr = cyc;
         chk("fd_avail", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) chk("fd", fd, exp_q.pop_front());
      end
      if (!pktend) begin
         pktends++;
         last_pk = cyc;
         if (!slwr) overlaps++;
      end
      rd_s = src_rdreq;
      if (rd_s && first_rd < 0) first_rd = cyc;
      @(posedge ifclk);
      if (reset) begin
         m_fr = 0; m_act = 0; m_tail = 0; m_pkt = 0; m_frame = 0;
         m_slwr = 1; m_pktend = 1; m_oe = 0;
      end else begin
         go = m_go();
         m_pktend = !(m_tail == 1);
         if (m_tail == 1) m_pkt = 0;
         m_slwr = !go;
         if (!go && !m_act && m_tail == 0) m_oe = 0;
         if (m_tail > 0) m_tail--;
         if (go) begin
            m_oe = 1;
            m_pkt = (m_pkt + 1) % PKT;
            if (src_last) begin
               m_frame++;
               m_act = 0;
               m_tail = (m_pkt != 0) ? 2 : 0;
            end else m_act = 1;
         end else if (!enable) m_act = 0;
         m_fr = flagb;
      end
      if (rd_s && src_q.size() > 0) void'(src_q.pop_front());
      cyc++;
      #1;
      drive_in();
   endtask
   task automatic run(int n);
      repeat (n) step();
   endtask
   task automatic push_frame(int n);
      for (int i = 0; i < n; i++) begin
         logic [15:0] d;
         bit l;
         d = 16'($urandom);
         l = (i == n - 1);
         src_q.push_back({l, d});
         exp_q.push_back(d);
      end
      drive_in();
   endtask
   task automatic clr_stats();
      writes = 0; pktends = 0; overlaps = 0; first_rd = -1; first_wr = -1; last_wr = -1; last_pk = -1;
   endtask
   initial begin
      repeat (3) @(posedge ifclk);
      #1;
      chk("rst_slwr", slwr, 1);
      chk("rst_pktend", pktend, 1);
      chk("rst_fd_oe", fd_oe, 0);
      chk("rst_fd", fd, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdreq", src_rdreq, 0);
      reset = 1'b0;
      drive_in();
      run(2);
      // full 256-word frame: back-to-back writes, auto-commit, no pktend
      clr_stats();
      push_frame(256);
      enable = 1'b1;
      drive_in();
      run(275);
      chk("t1_writes", writes, 256);
      chk("t1_pktends", pktends, 0);
      chk("t1_latency", first_wr - first_rd, 1);
      chk("t1_contiguous", last_wr - first_wr, 255);
      chk("t1_frame_cnt", frame_cnt, 1);
      chk("t1_drained", exp_q.size(), 0);
      // short frame: gap cycle then a single pktend
      clr_stats();
      push_frame(100);
      run(120);
      chk("t2_writes", writes, 100);
      chk("t2_pktends", pktends, 1);
      chk("t2_overlap", overlaps, 0);
      chk("t2_gap", last_pk - last_wr, 2);
      chk("t2_frame_cnt", frame_cnt, 2);
      // endpoint full at word 50 for 20 cycles
      clr_stats();
      push_frame(120);
      for (int i = 0; i < 200 && writes < 50; i++) step();
      chk("t3_reach50", int'(writes >= 50), 1);
      flagb = 1'b0;
      flag_low = 19;
      w0 = writes;
      run(18);
      chk("t3_extra_le2", int'(writes - w0 <= 2), 1);
      run(120);
      chk("t3_writes", writes, 120);
      chk("t3_pktends", pktends, 1);
      chk("t3_frame_cnt", frame_cnt, 3);
      chk("t3_drained", exp_q.size(), 0);
      // source empty every other cycle across a packet boundary
      clr_stats();
      hide_mode = 1;
      push_frame(300);
      run(700);
      hide_mode = 0;
      chk("t4_writes", writes, 300);
      chk("t4_pktends", pktends, 1);
      chk("t4_frame_cnt", frame_cnt, 4);
      // random flag/empty/enable over several frames
      flag_rand = 1;
      en_rand = 1;
      hide_mode = 2;
      for (int f = 0; f < 6; f++) begin
         push_frame($urandom_range(1, 40));
         run(60);
      end
      flag_rand = 0;
      en_rand = 0;
      hide_mode = 0;
      enable = 1'b1;
      drive_in();
      run(300);
      chk("t5_drained", exp_q.size(), 0);
      chk("t5_frame_cnt", frame_cnt, 10);
      // reset in the middle of a packet
      clr_stats();
      push_frame(80);
      for (int i = 0; i < 200 && writes < 37; i++) step();
      chk("t6_reach37", int'(writes >= 37), 1);
      reset = 1'b1;
      drive_in();
      step();
      chk("t6_slwr", slwr, 1);
      chk("t6_pktend", pktend, 1);
      chk("t6_fd_oe", fd_oe, 0);
      chk("t6_frame_cnt", frame_cnt, 0);
      chk("t6_busy", busy, 0);
      reset = 1'b0;
      src_q.delete();
      exp_q.delete();
      drive_in();
      run(3);
      // 17 one-word frames wrap the 4-bit frame counter
      clr_stats();
      for (int f = 0; f < 17; f++) begin
         push_frame(1);
         run(6);
      end
      chk("t7_writes", writes, 17);
      chk("t7_pktends", pktends, 17);
      chk("t7_overlap", overlaps, 0);
      chk("t7_frame_cnt", frame_cnt, 1);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
